io_bus_arbiter: RTL and testbench
=================================

Name: io_bus_arbiter

Overview:
- Shares the CPU's external 16-bit I/O bus (address bus plus the bidirectional data bus behind the transceiver) between the CPU and NREQ peripheral bus masters.
- The CPU has fixed top priority. Peripherals are served round-robin.
- Provides registered one-hot grants, the bus output-enable qualification for the CPU transceiver, a one-cycle turnaround between owners, and a burst limit with forced release.
- Sits beside the datapath at the top level, between the CPU bus pins and the peripheral masters.

Parameters:
- NREQ, 4, number of peripheral requesters (>= 2).
- MAXBURST, 8, maximum consecutive grant cycles per ownership (>= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- cpu_req  input  1  CPU requests the bus (level, held while needed).
- req  input  NREQ  peripheral requests, one bit per master (level).
- done  input  NREQ  one-cycle pulse from the owning master: transfer complete.
- cpu_gnt  output  1  CPU owns the bus.
- gnt  output  NREQ  one-hot peripheral grant.
- gnt_idx  output  $clog2(NREQ)  index of the granted peripheral; 0 when none is granted.
- busy  output  1  high whenever any grant is active.
- cpu_oe_en  output  1  CPU transceiver may drive the bus; equals cpu_gnt.
- timeout  output  1  one-cycle pulse when an ownership is ended by the burst limit.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - All outputs go to 0, state goes to IDLE, round-robin pointer goes to 0, burst counter goes to 0.
  - Reset takes effect even mid-grant, with no turnaround cycle.
- States: IDLE, GRANT, TURN. All outputs are registered.
- IDLE:
  - cpu_req == 1 → GRANT with cpu_gnt = 1.
  - Otherwise, if any req bit is set → GRANT with the gnt bit of the round-robin winner set.
  - Otherwise stay in IDLE.
- Round-robin winner: the first set req bit at or after the pointer, scanning upward and wrapping NREQ-1 → 0.
- On a peripheral grant, the pointer becomes (winner + 1) mod NREQ. A CPU grant leaves the pointer unchanged.
- Latency: a request sampled at edge k gives a grant visible after edge k (registered). Grant-to-grant gap is exactly one TURN cycle.
- GRANT:
  - The burst counter loads 1 on entry and increments each cycle in GRANT.
  - Release conditions, any of:
    - the owner's req/cpu_req is low;
    - the owner's done is high;
    - counter == MAXBURST.
  - On release: all grants are 0 after the edge and state goes to TURN.
  - If release is due to the counter while the owner's request is still high, timeout = 1 during the TURN cycle.
  - done from a non-owner is ignored.
  - A requester dropping req while not granted is simply not served.
- TURN:
  - One dead cycle: no grant, busy = 0, cpu_oe_en = 0. This guarantees no driver overlap on the bidirectional bus.
  - Arbitration is evaluated as in IDLE. Next state is GRANT if a request exists, otherwise IDLE.
  - The previous owner is allowed to win again if it is the only requester. A CPU still requesting after its own timeout wins again.
- The CPU never pre-empts an active peripheral grant. It wins at the next IDLE/TURN decision.
- Simultaneous cpu_req and req in IDLE/TURN: the CPU wins and the pointer is unchanged.
- MAXBURST == 1: every grant lasts exactly one cycle.
- Counter width is $clog2(MAXBURST+1). The counter never exceeds MAXBURST.
- Invariants:
  - cpu_gnt and |gnt are never both 1.
  - gnt is always one-hot or zero.
  - busy == cpu_gnt | (|gnt).

Decomposition:
- Shared package io_arb_pkg: state encoding (IDLE, GRANT, TURN as 2-bit constants) and an owner code constant for the CPU.
- One natural sub-module, rr_pick: combinational, req plus pointer → one-hot winner, index and valid. It is reusable by the interrupt controller.

Test Plan:
- Reset mid-grant: req = 4'b0010 granted, then reset low for one cycle → next cycle gnt = 0, busy = 0. After reset release with req = 4'b1111, the first grant is index 0 (pointer reset).
- Round-robin rotation: req = 4'b1111 held, each master pulses done on its first grant cycle → grant order 0, 1, 2, 3, 0, with one TURN cycle (busy = 0) between each grant.
- CPU priority, no pre-emption: master 2 granted; cpu_req rises at cycle 1 of that grant while master 2 runs to done at cycle 3 → cpu_gnt = 1 exactly after the TURN cycle. Master 2 and the CPU are never granted together.
- Burst limit: MAXBURST = 8, master 1 holds req with no done → gnt[1] high for exactly 8 cycles, timeout = 1 in the following TURN cycle. Master 1 is re-granted only if no other request is present.
- Non-owner done: master 3 owns the bus, done[0] is pulsed → no release; the grant continues.
- Wrap-around: pointer = 3, req = 4'b0001 → index 0 granted and the pointer becomes 1.

Source files
------------

// File: rtl/io_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// io_arb_pkg
// Shared definitions for the I/O bus arbiter:
//   state_t    : arbiter FSM encoding (IDLE, GRANT, TURN), 2 bits
//   owner_t    : which kind of master currently owns the bus
//   OWNER_CPU  : owner code meaning "the CPU holds the bus"
// ---------------------------------------------------------------------------
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // The peripheral index itself lives in the registered gnt_idx, so the
    // owner code only needs to say whether the CPU or a peripheral owns.
    typedef logic owner_t;
    localparam owner_t OWNER_CPU    = 1'b1;
    localparam owner_t OWNER_PERIPH = 1'b0;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// io_bus_arbiter_if
// Request/grant bundle between the bus masters and the arbiter.
//   cpu_req, req[NREQ], done[NREQ]        : driven by the masters
//   cpu_gnt, gnt[NREQ], gnt_idx, busy,
//   cpu_oe_en, timeout                    : driven by the arbiter
// Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface io_bus_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IW = $clog2(NREQ);

    logic            cpu_req;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic            cpu_gnt;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            busy;
    logic            cpu_oe_en;
    logic            timeout;

    modport master (
        output cpu_req, req, done,
        input  cpu_gnt, gnt, gnt_idx, busy, cpu_oe_en, timeout
    );

    modport slave (
        input  cpu_req, req, done,
        output cpu_gnt, gnt, gnt_idx, busy, cpu_oe_en, timeout
    );
endinterface

// File: rtl/io_bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: finds the first set request bit at or
// after ptr, scanning upward and wrapping N-1 -> 0.
//   req    [N]        : request vector
//   ptr    [clog2(N)] : scan start position
//   onehot [N]        : one-hot winner (zero when no request)
//   idx    [clog2(N)] : winner index (zero when no request)
//   valid             : at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);
    localparam int W = $clog2(N);

    // rot[k] is the request sitting k positions after the pointer, so the
    // lowest set bit of rot is the round-robin winner.
    logic [N-1:0] rot;
    logic [W-1:0] off;
    logic [W:0]   idx_sum;
    logic [W-1:0] idx_raw;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [W:0]   pos_sum;
            logic [W-1:0] pos;
            assign pos_sum = {1'b0, ptr} + (W+1)'(gi);
            assign pos     = (pos_sum >= (W+1)'(N)) ? W'(pos_sum - (W+1)'(N))
                                                    : pos_sum[W-1:0];
            assign rot[gi] = req[pos];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = W'(i);
            end
        end
    end

    assign valid   = |rot;
    assign idx_sum = {1'b0, ptr} + {1'b0, off};
    assign idx_raw = (idx_sum >= (W+1)'(N)) ? W'(idx_sum - (W+1)'(N))
                                            : idx_sum[W-1:0];
    assign idx     = valid ? idx_raw : '0;

    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign onehot[gi] = valid && (idx_raw == W'(gi));
        end
    endgenerate

endmodule

// File: rtl/io_bus_arbiter.sv
// ---------------------------------------------------------------------------
// io_bus_arbiter
// Shares the external 16-bit I/O bus between the CPU (fixed top priority)
// and NREQ peripheral masters (round-robin). Grants are registered, owners
// are separated by one dead TURN cycle, and each ownership is capped at
// MAXBURST cycles.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-low
//   bus    : io_bus_arbiter_if.slave
//            in : cpu_req, req[NREQ], done[NREQ]
//            out: cpu_gnt, gnt[NREQ], gnt_idx, busy, cpu_oe_en, timeout
// ---------------------------------------------------------------------------
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAXBURST = 8
) (
    input  logic             clk,
    input  logic             reset,
    io_bus_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAXBURST + 1);

    state_t          state_reg,   state_next;
    logic [IW-1:0]   ptr_reg,     ptr_next;
    logic [CW-1:0]   cnt_reg,     cnt_next;
    owner_t          owner_reg,   owner_next;
    logic            cpu_gnt_reg, cpu_gnt_next;
    logic [NREQ-1:0] gnt_reg,     gnt_next;
    logic [IW-1:0]   idx_reg,     idx_next;
    logic            busy_reg,    busy_next;
    logic            timeout_reg, timeout_next;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    logic            owner_req;
    logic            owner_done;
    logic            at_limit;

    rr_pick #(
        .N (NREQ)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // While granted, idx_reg holds the owning peripheral's index.
    assign owner_req  = (owner_reg == OWNER_CPU) ? bus.cpu_req : bus.req[idx_reg];
    assign owner_done = (owner_reg != OWNER_CPU) && bus.done[idx_reg];
    assign at_limit   = (cnt_reg == CW'(MAXBURST));

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        cnt_next     = cnt_reg;
        owner_next   = owner_reg;
        cpu_gnt_next = cpu_gnt_reg;
        gnt_next     = gnt_reg;
        idx_next     = idx_reg;
        timeout_next = 1'b0;

        case (state_reg)
            IDLE, TURN: begin
                state_next   = IDLE;
                cpu_gnt_next = 1'b0;
                gnt_next     = '0;
                idx_next     = '0;
                cnt_next     = '0;
                if (bus.cpu_req) begin
                    // CPU wins outright; the pointer is left alone so the
                    // peripherals resume their rotation where they were.
                    state_next   = GRANT;
                    cpu_gnt_next = 1'b1;
                    owner_next   = OWNER_CPU;
                    cnt_next     = CW'(1);
                end else if (pick_valid) begin
                    state_next = GRANT;
                    gnt_next   = pick_onehot;
                    idx_next   = pick_idx;
                    owner_next = OWNER_PERIPH;
                    cnt_next   = CW'(1);
                    ptr_next   = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
                end
            end

            GRANT: begin
                if (!owner_req || owner_done || at_limit) begin
                    state_next   = TURN;
                    cpu_gnt_next = 1'b0;
                    gnt_next     = '0;
                    idx_next     = '0;
                    cnt_next     = '0;
                    // Only flag a forced release: the owner still wanted
                    // the bus and had not signalled completion.
                    timeout_next = at_limit && owner_req && !owner_done;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            default: begin
                state_next   = IDLE;
                cpu_gnt_next = 1'b0;
                gnt_next     = '0;
                idx_next     = '0;
                cnt_next     = '0;
            end
        endcase

        busy_next = cpu_gnt_next | (|gnt_next);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
            owner_reg   <= OWNER_PERIPH;
            cpu_gnt_reg <= 1'b0;
            gnt_reg     <= '0;
            idx_reg     <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
            owner_reg   <= owner_next;
            cpu_gnt_reg <= cpu_gnt_next;
            gnt_reg     <= gnt_next;
            idx_reg     <= idx_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.cpu_gnt   = cpu_gnt_reg;
    assign bus.cpu_oe_en = cpu_gnt_reg;
    assign bus.gnt       = gnt_reg;
    assign bus.gnt_idx   = idx_reg;
    assign bus.busy      = busy_reg;
    assign bus.timeout   = timeout_reg;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_io_bus_arbiter
// Directed bench for io_bus_arbiter (NREQ = 4, MAXBURST = 8): a table of
// per-cycle vectors followed by hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_io_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    io_bus_arbiter_if #(.NREQ(4)) bus ();

    io_bus_arbiter #(
        .NREQ     (4),
        .MAXBURST (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst_n;
        logic       cpu_req;
        logic [3:0] req;
        logic [3:0] done;
        logic       e_cpu;
        logic [3:0] e_gnt;
        logic [1:0] e_idx;
        logic       e_to;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    int total  = 0;
    int passed = 0;

    function automatic vec_t mk(input logic r, input logic c, input logic [3:0] rq,
                                input logic [3:0] dn, input logic ec, input logic [3:0] eg,
                                input logic [1:0] ei, input logic et);
        vec_t v;
        v.rst_n = r;  v.cpu_req = c; v.req = rq; v.done = dn;
        v.e_cpu = ec; v.e_gnt = eg;  v.e_idx = ei; v.e_to = et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic r, input logic c, input logic [3:0] rq, input logic [3:0] dn);
        @(negedge clk);
        reset       = r;
        bus.cpu_req = c;
        bus.req     = rq;
        bus.done    = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ec, input logic [3:0] eg,
                             input logic [1:0] ei, input logic et);
        $display("%s: cpu_gnt=%0b gnt=%b idx=%0d busy=%0b oe=%0b timeout=%0b",
                 tag, bus.cpu_gnt, bus.gnt, bus.gnt_idx, bus.busy, bus.cpu_oe_en, bus.timeout);
        chk({tag, " cpu_gnt"},   32'(bus.cpu_gnt),   32'(ec));
        chk({tag, " gnt"},       32'(bus.gnt),       32'(eg));
        chk({tag, " gnt_idx"},   32'(bus.gnt_idx),   32'(ei));
        chk({tag, " busy"},      32'(bus.busy),      32'(ec | (|eg)));
        chk({tag, " cpu_oe_en"}, 32'(bus.cpu_oe_en), 32'(ec));
        chk({tag, " timeout"},   32'(bus.timeout),   32'(et));
    endtask

    initial begin
        bus.cpu_req = 1'b0;
        bus.req     = '0;
        bus.done    = '0;

        //               rst cpu req      done     ecpu egnt     eidx  eto
        // reset state
        vecs[0]  = mk(0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0);
        // grant master 1, then reset mid-grant
        vecs[1]  = mk(1, 0, 4'b0010, 4'b0000, 0, 4'b0010, 2'd1, 0);
        vecs[2]  = mk(0, 0, 4'b0010, 4'b0000, 0, 4'b0000, 2'd0, 0);
        // pointer back at 0: rotation 0,1,2,3,0 with a TURN between each
        vecs[3]  = mk(1, 0, 4'b1111, 4'b0000, 0, 4'b0001, 2'd0, 0);
        vecs[4]  = mk(1, 0, 4'b1111, 4'b0001, 0, 4'b0000, 2'd0, 0);
        vecs[5]  = mk(1, 0, 4'b1111, 4'b0000, 0, 4'b0010, 2'd1, 0);
        vecs[6]  = mk(1, 0, 4'b1111, 4'b0010, 0, 4'b0000, 2'd0, 0);
        vecs[7]  = mk(1, 0, 4'b1111, 4'b0000, 0, 4'b0100, 2'd2, 0);
        vecs[8]  = mk(1, 0, 4'b1111, 4'b0100, 0, 4'b0000, 2'd0, 0);
        vecs[9]  = mk(1, 0, 4'b1111, 4'b0000, 0, 4'b1000, 2'd3, 0);
        vecs[10] = mk(1, 0, 4'b1111, 4'b1000, 0, 4'b0000, 2'd0, 0);
        vecs[11] = mk(1, 0, 4'b1111, 4'b0000, 0, 4'b0001, 2'd0, 0);
        // done from a non-owner is ignored
        vecs[12] = mk(1, 0, 4'b1111, 4'b0010, 0, 4'b0001, 2'd0, 0);
        // owner drops req -> TURN -> IDLE
        vecs[13] = mk(1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0);
        vecs[14] = mk(1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0);
        // CPU and peripheral together: CPU wins, pointer (1) untouched
        vecs[15] = mk(1, 1, 4'b0100, 4'b0000, 1, 4'b0000, 2'd0, 0);
        vecs[16] = mk(1, 0, 4'b0100, 4'b0000, 0, 4'b0000, 2'd0, 0);
        vecs[17] = mk(1, 0, 4'b0100, 4'b0000, 0, 4'b0100, 2'd2, 0);
        // pointer = 3, only req[0]: wrap to index 0, pointer -> 1
        vecs[18] = mk(1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0);
        vecs[19] = mk(1, 0, 4'b0001, 4'b0000, 0, 4'b0001, 2'd0, 0);
        vecs[20] = mk(1, 0, 4'b0011, 4'b0001, 0, 4'b0000, 2'd0, 0);
        vecs[21] = mk(1, 0, 4'b0011, 4'b0000, 0, 4'b0010, 2'd1, 0);
        vecs[22] = mk(1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0);
        vecs[23] = mk(1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0);

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst_n, vecs[i].cpu_req, vecs[i].req, vecs[i].done);
            check_all($sformatf("vec%0d", i), vecs[i].e_cpu, vecs[i].e_gnt,
                      vecs[i].e_idx, vecs[i].e_to);
        end

        // CPU raises its request during master 2's grant; no pre-emption.
        // Pointer is 2 here, so master 2 wins from IDLE.
        step(1, 0, 4'b0100, 4'b0000);
        check_all("cpu_prio g1", 0, 4'b0100, 2'd2, 0);
        step(1, 1, 4'b0100, 4'b0000);
        check_all("cpu_prio g2", 0, 4'b0100, 2'd2, 0);
        step(1, 1, 4'b0100, 4'b0000);
        check_all("cpu_prio g3", 0, 4'b0100, 2'd2, 0);
        step(1, 1, 4'b0100, 4'b0100);
        check_all("cpu_prio turn", 0, 4'b0000, 2'd0, 0);
        step(1, 1, 4'b0000, 4'b0000);
        check_all("cpu_prio cpu", 1, 4'b0000, 2'd0, 0);
        step(1, 0, 4'b0000, 4'b0000);
        check_all("cpu_prio rel", 0, 4'b0000, 2'd0, 0);
        step(1, 0, 4'b0000, 4'b0000);
        check_all("cpu_prio idle", 0, 4'b0000, 2'd0, 0);

        // Burst limit: master 1 holds req with no done (pointer 3 -> scan 3,0,1).
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, 4'b0010, 4'b0000);
            check_all($sformatf("burst1 c%0d", k), 0, 4'b0010, 2'd1, 0);
        end
        step(1, 0, 4'b0010, 4'b0000);
        check_all("burst1 timeout", 0, 4'b0000, 2'd0, 1);
        // Only requester: re-granted, timeout is a single-cycle pulse.
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, 4'b0010, 4'b0000);
            check_all($sformatf("burst2 c%0d", k), 0, 4'b0010, 2'd1, 0);
        end
        step(1, 0, 4'b0010, 4'b0000);
        check_all("burst2 timeout", 0, 4'b0000, 2'd0, 1);
        // Another requester present: master 3 (pointer 2) takes over.
        step(1, 0, 4'b1010, 4'b0000);
        check_all("burst handoff", 0, 4'b1000, 2'd3, 0);
        step(1, 0, 4'b0000, 4'b0000);
        check_all("burst rel", 0, 4'b0000, 2'd0, 0);
        step(1, 0, 4'b0000, 4'b0000);
        check_all("burst idle", 0, 4'b0000, 2'd0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
